// File: rtl/dart_pkg.sv
// Shared constants, state encodings and scoring helpers for the dart game sequencer.
package dart_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_ARMED = 2'd1;
  localparam state_t ST_EVAL  = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  localparam int unsigned PTS_W      = 3;
  localparam int unsigned MAX_POINTS = 5;
  localparam int unsigned SAT_W      = 16;

  // Points above MAX_POINTS come from unused PRBS codes and score nothing.
  function automatic logic [PTS_W-1:0] decode_points(input logic [PTS_W-1:0] pts);
    return (pts > PTS_W'(MAX_POINTS)) ? '0 : pts;
  endfunction

  // Adds decoded points to a total, clamping at max_total.
  function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] total,
                                               input logic [PTS_W-1:0] pts,
                                               input logic [SAT_W-1:0] max_total);
    logic [SAT_W:0] sum;
    sum = {1'b0, total} + (SAT_W+1)'(decode_points(pts));
    if (sum > {1'b0, max_total}) return max_total;
    return sum[SAT_W-1:0];
  endfunction

endpackage

// File: rtl/dart_btn_edge.sv
// Per-bit button delay register with rising-edge detect; held buttons produce one rise.
module dart_btn_edge #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] btn,
  output logic [WIDTH-1:0] rise_c
);

  logic [WIDTH-1:0] btn_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) btn_q <= '0;
    else       btn_q <= btn;
  end

  assign rise_c = btn & ~btn_q;

endmodule

// File: rtl/dart_turn_controller.sv
// Dart game sequencer: turn/throw/round counting, button arbitration,
// saturating per-player totals and a serial end-of-game winner scan.
module dart_turn_controller
  import dart_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS     = 3,
  parameter int unsigned THROWS_PER_TURN = 5,
  parameter int unsigned NUM_ROUNDS      = 2,
  parameter int unsigned SCORE_W         = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [NUM_PLAYERS-1:0] throw_btn,
  input  logic [2:0]             points,
  output logic                   throw_accept,
  output logic                   foul,
  output logic [1:0]             cur_player,
  output logic [2:0]             throw_idx,
  output logic [2:0]             round_idx,
  output logic                   busy,
  output logic                   game_over,
  output logic [1:0]             winner,
  output logic [SCORE_W-1:0]     winner_score,
  output logic                   tie,
  input  logic [1:0]             rd_sel,
  output logic [SCORE_W-1:0]     rd_score
);

  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  state_t               state, state_nxt;
  logic [SCORE_W-1:0]   score [NUM_PLAYERS];
  logic [1:0]           eval_idx;
  logic [NUM_PLAYERS-1:0] rise_c;

  logic               cur_rise, other_rise;
  logic               accept_c, foul_c, clear_c;
  logic               turn_last, player_last, round_last;
  logic [SCORE_W-1:0] score_cur, score_next, eval_score;

  dart_btn_edge #(.WIDTH(NUM_PLAYERS)) u_btn_edge (
    .clk    (clk),
    .reset  (reset),
    .btn    (throw_btn),
    .rise_c (rise_c)
  );

  assign turn_last   = (throw_idx  == 3'(THROWS_PER_TURN - 1));
  assign player_last = (cur_player == 2'(NUM_PLAYERS - 1));
  assign round_last  = (round_idx  == 3'(NUM_ROUNDS - 1));

  // Operand muxes for the scoring datapath, the winner scan and readback.
  always_comb begin
    score_cur  = '0;
    eval_score = '0;
    rd_score   = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (cur_player == 2'(i)) score_cur  = score[i];
      if (eval_idx   == 2'(i)) eval_score = score[i];
      if (rd_sel     == 2'(i)) rd_score   = score[i];
    end
  end

  assign score_next = SCORE_W'(sat_add(SAT_W'(score_cur), points, SAT_W'(SCORE_MAX)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state and control strobes.
  always_comb begin
    state_nxt  = state;
    accept_c   = 1'b0;
    foul_c     = 1'b0;
    clear_c    = 1'b0;
    cur_rise   = 1'b0;
    other_rise = 1'b0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (cur_player == 2'(i)) cur_rise   = rise_c[i];
      else                     other_rise = other_rise | rise_c[i];
    end
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          clear_c   = 1'b1;
          state_nxt = ST_ARMED;
        end
      end
      ST_ARMED: begin
        accept_c = cur_rise;
        foul_c   = other_rise;
        if (cur_rise && turn_last && player_last && round_last) state_nxt = ST_EVAL;
      end
      ST_EVAL: begin
        if (eval_idx == 2'(NUM_PLAYERS - 1)) state_nxt = ST_DONE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      throw_accept <= 1'b0;
      foul         <= 1'b0;
      busy         <= 1'b0;
      game_over    <= 1'b0;
      cur_player   <= '0;
      throw_idx    <= '0;
      round_idx    <= '0;
      winner       <= '0;
      winner_score <= '0;
      tie          <= 1'b0;
      eval_idx     <= '0;
      for (int i = 0; i < NUM_PLAYERS; i++) score[i] <= '0;
    end else begin
      throw_accept <= accept_c;
      foul         <= foul_c;
      busy         <= (state_nxt == ST_ARMED) || (state_nxt == ST_EVAL);
      game_over    <= (state_nxt == ST_DONE);
      if (clear_c) begin
        cur_player   <= '0;
        throw_idx    <= '0;
        round_idx    <= '0;
        winner       <= '0;
        winner_score <= '0;
        tie          <= 1'b0;
        eval_idx     <= '0;
        for (int i = 0; i < NUM_PLAYERS; i++) score[i] <= '0;
      end else if (accept_c) begin
        for (int i = 0; i < NUM_PLAYERS; i++) begin
          if (cur_player == 2'(i)) score[i] <= score_next;
        end
        if (turn_last) begin
          throw_idx <= '0;
          eval_idx  <= '0;
          // The final throw of the game holds player/round for the scan.
          if (!(player_last && round_last)) begin
            if (player_last) begin
              cur_player <= '0;
              round_idx  <= round_idx + 3'd1;
            end else begin
              cur_player <= cur_player + 2'd1;
            end
          end
        end else begin
          throw_idx <= throw_idx + 3'd1;
        end
      end else if (state == ST_EVAL) begin
        eval_idx <= eval_idx + 2'd1;
        // Player 0 seeds the scan; later players must strictly beat it to win.
        if (eval_idx == 2'd0) begin
          winner       <= '0;
          winner_score <= eval_score;
          tie          <= 1'b0;
        end else if (eval_score > winner_score) begin
          winner       <= eval_idx;
          winner_score <= eval_score;
          tie          <= 1'b0;
        end else if (eval_score == winner_score) begin
          tie <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/dart_turn_controller.md
# dart_turn_controller

Game sequencer for the digital dart game. It owns turn order, throw counting and round counting, and arbitrates the per-player throw buttons so only the current player can score. It adds each accepted throw's points (0..5, from the existing PRBS points generator) into per-player saturating totals. At game end it scans the totals serially to declare a winner.

## Interface
Parameters:
- NUM_PLAYERS, 3: players, 2..4
- THROWS_PER_TURN, 5: throws per player per turn, 1..7
- NUM_ROUNDS, 2: full rotations per game, 1..7
- SCORE_W, 8: per-player total width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; all state to reset values
- start  in  1  level; begins a game from IDLE or DONE
- throw_btn  in  NUM_PLAYERS  raw per-player buttons, already synchronous to clk
- points  in  3  current points value 0..5; values 6..7 are treated as 0
- throw_accept  out  1  one-cycle pulse per accepted throw
- foul  out  1  one-cycle pulse; a non-current player pressed
- cur_player  out  2  player index of the current turn, 0-based
- throw_idx  out  3  throws taken in the current turn
- round_idx  out  3  current round, 0-based
- busy  out  1  high in ARMED and EVAL
- game_over  out  1  high in DONE
- winner  out  2  winning player index; valid while game_over
- winner_score  out  SCORE_W  winning total; valid while game_over
- tie  out  1  another player equals winner_score; valid while game_over
- rd_sel  in  2  score readback select
- rd_score  out  SCORE_W  combinational total of player rd_sel; 0 if rd_sel >= NUM_PLAYERS

## Operation
- States: IDLE, ARMED, EVAL, DONE.
- Edge detect: btn_q holds throw_btn delayed one cycle. A press is rise = throw_btn & ~btn_q. Held buttons count once.
- IDLE, start=1:
  - Clear all totals, cur_player, throw_idx, round_idx, winner, tie.
  - Go to ARMED.
- ARMED, rise[cur_player]=1:
  - score[cur] <= min(score[cur] + points, 2^SCORE_W-1).
  - throw_accept pulses.
  - throw_idx increments.
- End of turn (throw_idx reaches THROWS_PER_TURN):
  - throw_idx <= 0 and cur_player advances.
  - Wrap from NUM_PLAYERS-1 to 0 increments round_idx.
  - The last throw of player NUM_PLAYERS-1 in round NUM_ROUNDS-1 goes to EVAL instead.
- ARMED, any rise on a non-current bit: foul pulses and no score changes. This holds even if the current player's rise occurs in the same cycle; both the throw and the foul are processed.
- EVAL scans totals serially, one player per cycle, index 0 first:
  - A player is taken as best if its total is strictly greater than best.
  - Equal to best sets tie.
  - Lowest index wins ties.
  - After NUM_PLAYERS cycles, go to DONE.
- DONE:
  - Hold all results.
  - start=1 restarts exactly as from IDLE.
- start is ignored in ARMED and EVAL. Button edges are ignored outside ARMED, but btn_q still tracks.

## Timing
- Reset values: state IDLE; all totals 0; btn_q 0; every output 0.
- Throw latency: the press edge is seen the cycle after the button rises. On that clock edge:
  - throw_accept/foul are registered high for exactly one cycle.
  - The total is updated; rd_score shows the new value.
- points is sampled on the accepting edge.
- Max accept rate: one throw per 2 cycles per player, since the button must fall and rise again.
- EVAL: NUM_PLAYERS cycles. game_over rises on the cycle after the final accepted throw + NUM_PLAYERS.
- Reset asserted mid-game: immediate abort to IDLE and all scores cleared. No pulse is emitted after reset deasserts until a new press.

## Structure
- Shared package dart_pkg:
  - State enum.
  - Points-decode constants (MAX_POINTS=5).
  - Saturating-add function reused by the scoring datapath.
- Sub-module dart_btn_edge: a per-bit register plus rise detect, parameterised by width.
- Totals are held in a register array indexed by cur_player; no memory inference.

## Test plan
- Reset, start, player 0 presses 5 times with points=3 → five throw_accept pulses, score[0]=15, cur_player becomes 1, throw_idx=0.
- Player 1 and player 2 rise in the same cycle while player 1 is current → throw_accept and foul both pulse; only score[1] changes.
- Button held high for 10 cycles → exactly one throw accepted.
- Full game (3×5×2 = 30 throws) with points 5,4,3 per player respectively:
  - game_over after 30 throws + 3 cycles.
  - winner=0, winner_score=50, tie=0.
- All players score 20 → winner=0, tie=1.
- SCORE_W=4, player 0 scores 5×5 → score[0] saturates at 15.
- Reset at throw 7, then start → all scores 0, round_idx=0, no spurious pulses.
